// File: rtl/as6s_ecc_scrub_ctrl_if.sv
// Buffer-side port bundle of the ECC scrub engine: read/write request-grant,
// shared address, write-back data, and the aligned read data plus ECC flags.
interface as6s_ecc_scrub_ctrl_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 128
);
    logic                  rd_req;
    logic                  rd_gnt;
    logic                  wr_req;
    logic                  wr_gnt;
    logic [ADDR_WIDTH-1:0] scrub_addr;
    logic [DATA_WIDTH-1:0] scrub_wdata;
    logic [DATA_WIDTH-1:0] QB_F;
    logic                  SINGLE_ERR_B;
    logic                  DOUBLE_ERR_B;
    logic                  ECC_FAULT_B;

    // Scrub engine side
    modport master (
        output rd_req, wr_req, scrub_addr, scrub_wdata,
        input  rd_gnt, wr_gnt, QB_F, SINGLE_ERR_B, DOUBLE_ERR_B, ECC_FAULT_B
    );

    // Buffer / arbiter side
    modport slave (
        input  rd_req, wr_req, scrub_addr, scrub_wdata,
        output rd_gnt, wr_gnt, QB_F, SINGLE_ERR_B, DOUBLE_ERR_B, ECC_FAULT_B
    );
endinterface

// File: rtl/as6s_ecc_scrub_ctrl.sv
// Background ECC scrub engine: sweeps every buffer address, reads it, counts
// single/double-bit errors and faults, and (optionally) writes corrected data
// back for single-bit errors.
// Optional feature macro: AS6S_ECC_SCRUB_WB_EN enables the write-back path and
// the host-write hazard snoop; without it single-bit errors are only counted.
module as6s_ecc_scrub_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 128,
    parameter int RD_LAT     = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scrub_en,
    input  logic [15:0]           interval_cfg,
    input  logic                  cnt_clr,
    as6s_ecc_scrub_ctrl_if.master bus,
    input  logic                  host_wr_cs,
    input  logic                  host_wr_we,
    input  logic [ADDR_WIDTH-1:0] host_wr_addr,
    output logic [CNT_WIDTH-1:0]  sbe_cnt,
    output logic [CNT_WIDTH-1:0]  dbe_cnt,
    output logic [ADDR_WIDTH-1:0] last_dbe_addr,
    output logic                  fault_sticky,
    output logic                  dbe_irq,
    output logic                  sweep_done,
    output logic                  busy
);

    // RD_WAIT countdown preload; RD_WAIT lasts RD_LAT-1 cycles
    localparam int WAIT_CYC = (RD_LAT > 1) ? RD_LAT - 2 : 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GAP     = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        CHECK   = 3'd4
`ifdef AS6S_ECC_SCRUB_WB_EN
        , WB_REQ = 3'd5
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            wait_cnt_q;
    logic [15:0]           gap_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] last_dbe_q;
    logic [CNT_WIDTH-1:0]  sbe_q;
    logic [CNT_WIDTH-1:0]  dbe_q;
    logic                  fault_q;
    logic                  irq_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  rd_req_q;
    logic                  issue;
    logic                  complete;
    logic                  sbe_hit;
    logic                  dbe_hit;

`ifdef AS6S_ECC_SCRUB_WB_EN
    logic                  wr_req_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  cancel_q;
    logic                  hazard;

    assign hazard = host_wr_cs & host_wr_we & (host_wr_addr == addr_q);
`else
    logic unused_inputs;
    assign unused_inputs = ^{host_wr_cs, host_wr_we, host_wr_addr, bus.wr_gnt, bus.QB_F};
`endif

    // Saturating counter step; a clear coinciding with an increment yields 1
    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
                                                      input logic inc, input logic clr);
        if (clr)
            return inc ? CNT_WIDTH'(1) : '0;
        if (inc && (cur != '1))
            return cur + CNT_WIDTH'(1);
        return cur;
    endfunction

    // Next-state decode; address completion overrides the per-state target
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        complete = 1'b0;
        sbe_hit  = (state_q == CHECK) & bus.SINGLE_ERR_B & ~bus.DOUBLE_ERR_B & ~bus.ECC_FAULT_B;
        dbe_hit  = (state_q == CHECK) & (bus.DOUBLE_ERR_B | bus.ECC_FAULT_B);
        case (state_q)
            IDLE:    if (scrub_en) state_d = RD_REQ;
            GAP: begin
                if (!scrub_en)              state_d = IDLE;
                else if (gap_cnt_q == '0)   state_d = RD_REQ;
            end
            RD_REQ: begin
                if (bus.rd_gnt) begin
                    issue   = 1'b1;
                    state_d = (RD_LAT > 1) ? RD_WAIT : CHECK;
                end else if (!scrub_en) begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: if (wait_cnt_q == '0) state_d = CHECK;
            CHECK: begin
`ifdef AS6S_ECC_SCRUB_WB_EN
                if (sbe_hit && !cancel_q && !hazard) state_d = WB_REQ;
                else                                 complete = 1'b1;
`else
                complete = 1'b1;
`endif
            end
`ifdef AS6S_ECC_SCRUB_WB_EN
            WB_REQ:  if (bus.wr_gnt || hazard) complete = 1'b1;
`endif
            default: state_d = IDLE;
        endcase
        if (complete)
            state_d = !scrub_en ? IDLE : ((interval_cfg != '0) ? GAP : RD_REQ);
    end

    // State, registered handshake outputs, counters and logging
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            gap_cnt_q  <= '0;
            addr_q     <= '0;
            last_dbe_q <= '0;
            sbe_q      <= '0;
            dbe_q      <= '0;
            fault_q    <= 1'b0;
            irq_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            rd_req_q   <= 1'b0;
`ifdef AS6S_ECC_SCRUB_WB_EN
            wr_req_q   <= 1'b0;
            wdata_q    <= '0;
            cancel_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rd_req_q <= (state_d == RD_REQ);
            busy_q   <= (state_d != IDLE);
            if (issue)
                wait_cnt_q <= 8'(WAIT_CYC);
            else if ((state_q == RD_WAIT) && (wait_cnt_q != '0))
                wait_cnt_q <= wait_cnt_q - 8'd1;
            if (complete)
                gap_cnt_q <= interval_cfg - 16'd1;
            else if ((state_q == GAP) && (gap_cnt_q != '0))
                gap_cnt_q <= gap_cnt_q - 16'd1;
            if (complete)
                addr_q <= addr_q + ADDR_WIDTH'(1);
            done_q <= complete & (addr_q == '1);
            irq_q  <= dbe_hit;
            if (dbe_hit)
                last_dbe_q <= addr_q;
            sbe_q <= cnt_next(sbe_q, sbe_hit, cnt_clr);
            dbe_q <= cnt_next(dbe_q, dbe_hit, cnt_clr);
            if (dbe_hit && bus.ECC_FAULT_B)
                fault_q <= 1'b1;
            else if (cnt_clr)
                fault_q <= 1'b0;
`ifdef AS6S_ECC_SCRUB_WB_EN
            wr_req_q <= (state_d == WB_REQ);
            if (state_q == CHECK)
                wdata_q <= bus.QB_F;
            // Hazard window opens on the issue cycle itself
            if (issue)
                cancel_q <= hazard;
            else if (hazard)
                cancel_q <= 1'b1;
`endif
        end
    end

    assign bus.rd_req     = rd_req_q;
    assign bus.scrub_addr = addr_q;
`ifdef AS6S_ECC_SCRUB_WB_EN
    assign bus.wr_req      = wr_req_q;
    assign bus.scrub_wdata = wdata_q;
`else
    assign bus.wr_req      = 1'b0;
    assign bus.scrub_wdata = '0;
`endif
    assign sbe_cnt       = sbe_q;
    assign dbe_cnt       = dbe_q;
    assign last_dbe_addr = last_dbe_q;
    assign fault_sticky  = fault_q;
    assign dbe_irq       = irq_q;
    assign sweep_done    = done_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_as6s_ecc_scrub_ctrl.sv
// Self-checking bench for as6s_ecc_scrub_ctrl: a small SRAM model returns
// per-address data/flags RD_LAT cycles after each granted read; each sweep's
// expected reads, spacing, write-backs and counters come from a per-address
// reference model.
module tb_as6s_ecc_scrub_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 128;
    localparam int RL    = 2;
    localparam int CW    = 3;
    localparam int NADDR = 1 << AW;
    localparam int CMAX  = (1 << CW) - 1;
`ifdef AS6S_ECC_SCRUB_WB_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, scrub_en, cnt_clr, host_wr_cs, host_wr_we;
    logic [15:0]   interval_cfg;
    logic [AW-1:0] host_wr_addr;
    logic [CW-1:0] sbe_cnt, dbe_cnt;
    logic [AW-1:0] last_dbe_addr;
    logic          fault_sticky, dbe_irq, sweep_done, busy;

    as6s_ecc_scrub_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    as6s_ecc_scrub_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(RL), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .scrub_en(scrub_en), .interval_cfg(interval_cfg),
        .cnt_clr(cnt_clr), .bus(bus), .host_wr_cs(host_wr_cs), .host_wr_we(host_wr_we),
        .host_wr_addr(host_wr_addr), .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt),
        .last_dbe_addr(last_dbe_addr), .fault_sticky(fault_sticky), .dbe_irq(dbe_irq),
        .sweep_done(sweep_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // SRAM model: kind 0 clean, 1 SBE, 2 DBE, 3 FAULT
    int unsigned   kind [NADDR];
    logic [DW-1:0] mem  [NADDR];
    logic [RL-1:0] pv = '0;
    logic [AW-1:0] pa [RL];
    int            cyc = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        pv    <= {pv[RL-2:0], bus.rd_req & bus.rd_gnt};
        pa[0] <= bus.scrub_addr;
        for (int i = 1; i < RL; i++) pa[i] <= pa[i-1];
    end

    assign bus.QB_F         = pv[RL-1] ? mem[pa[RL-1]] : '0;
    assign bus.SINGLE_ERR_B = pv[RL-1] && (kind[pa[RL-1]] == 1);
    assign bus.DOUBLE_ERR_B = pv[RL-1] && (kind[pa[RL-1]] == 2);
    assign bus.ECC_FAULT_B  = pv[RL-1] && (kind[pa[RL-1]] == 3);

    int            checks = 0, errors = 0;
    int            rd_cyc[$], wr_cyc[$];
    logic [AW-1:0] rd_adr[$], wr_adr[$];
    logic [DW-1:0] wr_dat[$];
    int            irq_n, done_n;
    logic          prev_rd = 1'b0, prev_wr = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    int            m_addr = 0, m_sbe = 0, m_dbe = 0, m_last = 0;
    bit            m_fault = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Per-cycle observation, called once at every negedge inside a sweep
    task automatic sample();
        if (bus.rd_req && bus.rd_gnt) begin
            rd_cyc.push_back(cyc);
            rd_adr.push_back(bus.scrub_addr);
        end
        if (bus.wr_req && !prev_wr) begin
            wr_cyc.push_back(cyc);
            wr_adr.push_back(bus.scrub_addr);
            wr_dat.push_back(bus.scrub_wdata);
        end
        if (dbe_irq)    irq_n++;
        if (sweep_done) done_n++;
        chk("req_exclusive", DW'(bus.rd_req & bus.wr_req), '0);
        if ((bus.rd_req && prev_rd) || (bus.wr_req && prev_wr))
            chk("addr_stable", DW'(bus.scrub_addr), DW'(prev_addr));
        prev_rd   = bus.rd_req;
        prev_wr   = bus.wr_req;
        prev_addr = bus.scrub_addr;
    endtask

    task automatic clear_inj();
        for (int a = 0; a < NADDR; a++) begin
            kind[a] = 0;
            mem[a]  = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // One sweep of n reads from the current address; optional host-write
    // hazard (mode 0 cancel, 1 other address, 2 we low) and cnt_clr pulse.
    task automatic run_sweep(input int n, input int hz_a, input int hz_off,
                             input int hz_mode, input int clr_a);
        int            start, hz_t, clr_t, budget, a, wbx, exp_irq, exp_done;
        int            gapv[NADDR];
        int            wb_i[$];
        logic [AW-1:0] wb_a[$];
        logic [DW-1:0] wb_d[$];
        start = m_addr; hz_t = -1; clr_t = -1; exp_irq = 0; exp_done = 0;
        rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete(); wr_adr.delete(); wr_dat.delete();
        irq_n = 0; done_n = 0;
        scrub_en = 1'b1;
        for (budget = 0; budget < 600; budget++) begin
            @(negedge clk);
            host_wr_cs = 1'b0; host_wr_we = 1'b0; host_wr_addr = '0; cnt_clr = 1'b0;
            sample();
            if (bus.rd_req && bus.rd_gnt && (int'(bus.scrub_addr) == hz_a))  hz_t  = hz_off;
            if (bus.rd_req && bus.rd_gnt && (int'(bus.scrub_addr) == clr_a)) clr_t = RL;
            if (hz_t == 0) begin
                host_wr_cs   = 1'b1;
                host_wr_we   = (hz_mode != 2);
                host_wr_addr = (hz_mode == 1) ? AW'(hz_a ^ 1) : AW'(hz_a);
            end
            if (clr_t == 0) cnt_clr = 1'b1;
            if (hz_t >= 0)  hz_t--;
            if (clr_t >= 0) clr_t--;
            if (rd_cyc.size() >= n) scrub_en = 1'b0;
            if (!scrub_en && !busy && (rd_cyc.size() >= n)) break;
        end
        scrub_en = 1'b0; host_wr_cs = 1'b0; host_wr_we = 1'b0; cnt_clr = 1'b0;
        chk("sweep_in_budget", DW'(budget < 600), DW'(1));

        // Reference: per-address outcome in sweep order
        for (int i = 0; i < n; i++) begin
            a = (start + i) % NADDR;
            wbx = 0;
            if (a == clr_a) begin m_sbe = 0; m_dbe = 0; m_fault = 1'b0; end
            if (kind[a] == 1) begin
                m_sbe = sat(m_sbe);
                if (WB && !(a == hz_a && hz_mode == 0)) begin
                    wb_i.push_back(i); wb_a.push_back(AW'(a)); wb_d.push_back(mem[a]);
                    wbx = 1;
                end
            end else if (kind[a] >= 2) begin
                m_dbe = sat(m_dbe); m_last = a; exp_irq++;
                if (kind[a] == 3) m_fault = 1'b1;
            end
            if (a == NADDR - 1) exp_done++;
            gapv[i] = RL + 1 + int'(interval_cfg) + wbx;
        end
        m_addr = (start + n) % NADDR;

        chk("rd_count", DW'(rd_cyc.size()), DW'(n));
        for (int i = 0; i < n && i < rd_cyc.size(); i++) begin
            chk("rd_addr", DW'(rd_adr[i]), DW'((start + i) % NADDR));
            if (i > 0) chk("rd_spacing", DW'(rd_cyc[i] - rd_cyc[i-1]), DW'(gapv[i-1]));
        end
        chk("wb_count", DW'(wr_cyc.size()), DW'(wb_i.size()));
        for (int j = 0; j < wb_i.size() && j < wr_cyc.size(); j++) begin
            chk("wb_addr", DW'(wr_adr[j]), DW'(wb_a[j]));
            chk("wb_data", wr_dat[j], wb_d[j]);
            if (wb_i[j] < rd_cyc.size())
                chk("wb_latency", DW'(wr_cyc[j] - rd_cyc[wb_i[j]]), DW'(RL + 1));
        end
        chk("sbe_cnt", DW'(sbe_cnt), DW'(m_sbe));
        chk("dbe_cnt", DW'(dbe_cnt), DW'(m_dbe));
        chk("last_dbe_addr", DW'(last_dbe_addr), DW'(m_last));
        chk("fault_sticky", DW'(fault_sticky), DW'(m_fault));
        chk("dbe_irq_pulses", DW'(irq_n), DW'(exp_irq));
        chk("sweep_done_pulses", DW'(done_n), DW'(exp_done));
        chk("end_addr", DW'(bus.scrub_addr), DW'(m_addr));
        chk("end_idle", DW'(busy), '0);
        if (!WB) chk("wdata_tied", bus.scrub_wdata, '0);
    endtask

    initial begin
        rst = 1'b1; scrub_en = 1'b0; cnt_clr = 1'b0; host_wr_cs = 1'b0; host_wr_we = 1'b0;
        host_wr_addr = '0; interval_cfg = '0; bus.rd_gnt = 1'b1; bus.wr_gnt = 1'b1;
        clear_inj();
        repeat (3) @(negedge clk);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_rd_req", DW'(bus.rd_req), '0);
        chk("rst_wr_req", DW'(bus.wr_req), '0);
        chk("rst_addr", DW'(bus.scrub_addr), '0);
        chk("rst_wdata", bus.scrub_wdata, '0);
        chk("rst_sbe", DW'(sbe_cnt), '0);
        chk("rst_dbe", DW'(dbe_cnt), '0);
        chk("rst_fault", DW'(fault_sticky), '0);
        rst = 1'b0;
        @(negedge clk);

        // Clean full sweep
        run_sweep(16, -1, 0, 0, -1);
        // SBE at 5 with A5 pattern
        clear_inj(); kind[5] = 1; mem[5] = {16{8'hA5}};
        run_sweep(16, -1, 0, 0, -1);
        // DBE at 9, FAULT at 12
        clear_inj(); kind[9] = 2; kind[12] = 3;
        run_sweep(16, -1, 0, 0, -1);
        // SBE at 7 with matching host write during RD_WAIT
        clear_inj(); kind[7] = 1;
        run_sweep(16, 7, 1, 0, -1);

        // Read grant withheld, then enable dropped: abort keeps the address
        clear_inj(); bus.rd_gnt = 1'b0; scrub_en = 1'b1;
        repeat (10) begin @(negedge clk); sample(); end
        chk("stall_rd_req", DW'(bus.rd_req), DW'(1));
        chk("stall_busy", DW'(busy), DW'(1));
        scrub_en = 1'b0;
        @(negedge clk); sample();
        chk("abort_busy", DW'(busy), '0);
        chk("abort_rd_req", DW'(bus.rd_req), '0);
        chk("abort_addr", DW'(bus.scrub_addr), DW'(m_addr));
        bus.rd_gnt = 1'b1;
        run_sweep(1, -1, 0, 0, -1);

        // Gap of 3 with a clear coinciding with an SBE increment
        clear_inj(); kind[4] = 1; kind[2] = 3; interval_cfg = 16'd3;
        run_sweep(16, -1, 0, 0, 4);

        // Saturation of both counters
        interval_cfg = '0;
        for (int a = 0; a < NADDR; a++) kind[a] = (a % 2 == 0) ? 1 : 2;
        run_sweep(16, -1, 0, 0, -1);

        // Randomized sweeps
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < NADDR; a++) begin
                int unsigned roll;
                roll    = $urandom_range(0, 9);
                kind[a] = (roll < 6) ? 0 : (roll < 8) ? 1 : (roll == 8) ? 2 : 3;
                mem[a]  = {$urandom, $urandom, $urandom, $urandom};
            end
            interval_cfg = 16'($urandom_range(0, 3));
            run_sweep(int'($urandom_range(5, 16)), int'($urandom_range(0, NADDR - 1)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1);
        end

        // Reset during CHECK of an SBE: nothing is counted or written back
        interval_cfg = '0;
        for (int a = 0; a < NADDR; a++) kind[a] = 1;
        scrub_en = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); sample();
            if (bus.rd_req && bus.rd_gnt) break;
        end
        chk("rst_mid_issue", DW'(bus.rd_req & bus.rd_gnt), DW'(1));
        repeat (2) @(negedge clk);
        rst = 1'b1; scrub_en = 1'b0;
        @(negedge clk);
        chk("rst_mid_wr_req", DW'(bus.wr_req), '0);
        chk("rst_mid_busy", DW'(busy), '0);
        chk("rst_mid_sbe", DW'(sbe_cnt), '0);
        chk("rst_mid_dbe", DW'(dbe_cnt), '0);
        chk("rst_mid_addr", DW'(bus.scrub_addr), '0);
        chk("rst_mid_last", DW'(last_dbe_addr), '0);
        chk("rst_mid_wdata", bus.scrub_wdata, '0);
        @(negedge clk);
        chk("rst_mid_wr_req2", DW'(bus.wr_req), '0);
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
